// File: rtl/seq_pattern_gen_if.sv
// ----------------------------------------------------------------------------
// seq_pattern_gen_if
//   Control/stream bundle for seq_pattern_gen.
//   master (requester): drives start, pattern, repeat_cnt, gap;
//                       observes out, bit_valid, busy, done.
//   slave  (generator): the reverse.
//   Signals:
//     start       1       request a transmission (taken only while not busy)
//     pattern     WIDTH   bits to send, MSB first
//     repeat_cnt  REP_W   extra repetitions (total sends = repeat_cnt+1)
//     gap         GAP_W   idle cycles between repetitions
//     out         1       serial bit stream
//     bit_valid   1       out carries a pattern bit
//     busy        1       transfer in progress (accept through done cycle)
//     done        1       one-cycle pulse after the final bit
// ----------------------------------------------------------------------------
interface seq_pattern_gen_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] repeat_cnt;
    logic [GAP_W-1:0] gap;
    logic             out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_cnt, gap,
        input  out, bit_valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_cnt, gap,
        output out, bit_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// ----------------------------------------------------------------------------
// seq_pattern_gen
//   Serial pattern transmitter. Latches a WIDTH-bit pattern on start and
//   shifts it out MSB-first, one bit per clock, repeating repeat_cnt extra
//   times with 'gap' idle cycles between sends, then pulses done.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    seq_pattern_gen_if.slave (start/pattern/repeat_cnt/gap in,
//            out/bit_valid/busy/done out)
//   All outputs are registered; out changes only after posedge clk.
// ----------------------------------------------------------------------------
module seq_pattern_gen #(
    parameter int WIDTH = 4,
    parameter int REP_W = 8,
    parameter int GAP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_pattern_gen_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_pat;       // latched copy, reloaded for each repetition
    logic [WIDTH-1:0] r_shift;     // r_shift[WIDTH-1] is the bit currently on out
    logic [CW-1:0]    r_bit_cnt;
    logic [REP_W-1:0] r_reps;      // repetitions still owed after the current send
    logic [GAP_W-1:0] r_gap;
    logic [GAP_W-1:0] r_gap_cnt;   // remaining idle cycles minus one
    logic             r_out;
    logic             r_bit_valid;
    logic             r_busy;
    logic             r_done;

    assign bus.out       = r_out;
    assign bus.bit_valid = r_bit_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pat       <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_reps      <= '0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_out       <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        // First bit goes out right after the accepting edge.
                        r_pat       <= bus.pattern;
                        r_shift     <= bus.pattern;
                        r_reps      <= bus.repeat_cnt;
                        r_gap       <= bus.gap;
                        r_bit_cnt   <= '0;
                        r_out       <= bus.pattern[WIDTH-1];
                        r_bit_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end else begin
                        r_out       <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        if (r_reps != '0) begin
                            r_reps <= r_reps - REP_W'(1);
                            if (r_gap != '0) begin
                                r_gap_cnt   <= r_gap - GAP_W'(1);
                                r_out       <= 1'b0;
                                r_bit_valid <= 1'b0;
                                r_state     <= GAP;
                            end else begin
                                // Back-to-back repetition, no bubble.
                                r_shift   <= r_pat;
                                r_bit_cnt <= '0;
                                r_out     <= r_pat[WIDTH-1];
                            end
                        end else begin
                            r_out       <= 1'b0;
                            r_bit_valid <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_shift   <= r_shift << 1;
                        r_out     <= r_shift[WIDTH-2];
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end

                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_shift     <= r_pat;
                        r_bit_cnt   <= '0;
                        r_out       <= r_pat[WIDTH-1];
                        r_bit_valid <= 1'b1;
                        r_state     <= SHIFT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                DONE: begin
                    // done clears via the default above; start here is dropped.
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.WIDTH(4), .REP_W(8), .GAP_W(4)) if4 ();
    seq_pattern_gen_if #(.WIDTH(8), .REP_W(2), .GAP_W(4)) if8 ();

    seq_pattern_gen #(.WIDTH(4), .REP_W(8), .GAP_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    seq_pattern_gen #(.WIDTH(8), .REP_W(2), .GAP_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(if8)
    );

    int n_pass = 0;
    int n_total = 0;

    // Expected per-cycle {out, bit_valid, busy, done}
    logic [3:0] exp_q[$];

    typedef struct {
        logic [7:0] pat;
        int         r;
        int         g;
        int         busy;
        string      name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    function automatic logic [3:0] obs(input bit sel);
        if (sel) return {if8.out, if8.bit_valid, if8.busy, if8.done};
        return {if4.out, if4.bit_valid, if4.busy, if4.done};
    endfunction

    // Reference stream: sends separated by gaps, then the done cycle, then idle.
    function automatic void build(input logic [7:0] pat, input int w, input int r, input int g);
        exp_q.delete();
        for (int rep = 0; rep <= r; rep++) begin
            for (int i = w - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
            if (rep < r) for (int k = 0; k < g; k++) exp_q.push_back(4'b0010);
        end
        exp_q.push_back(4'b0011);
        exp_q.push_back(4'b0000);
    endfunction

    task automatic scramble(input bit sel, input bit hold);
        if (sel) begin
            if8.pattern = 8'($urandom); if8.repeat_cnt = 2'($urandom);
            if8.gap = 4'($urandom); if8.start = hold;
        end else begin
            if4.pattern = 4'($urandom); if4.repeat_cnt = 8'($urandom);
            if4.gap = 4'($urandom); if4.start = hold;
        end
    endtask

    // Starts a transfer, checks every cycle against the model, and ends at the
    // sample point of the first idle cycle after done.
    task automatic run_xfer(input bit sel, input logic [7:0] pat, input int r, input int g,
                            input bit hold, input bit rel_rst, input int exp_busy,
                            input string name);
        int busy_cnt;
        logic [3:0] o;
        @(negedge clk);
        if (rel_rst) rst_n = 1'b1;
        if (sel) begin
            if8.pattern = pat; if8.repeat_cnt = r[1:0]; if8.gap = g[3:0]; if8.start = 1'b1;
        end else begin
            if4.pattern = pat[3:0]; if4.repeat_cnt = r[7:0]; if4.gap = g[3:0]; if4.start = 1'b1;
        end
        build(pat, sel ? 8 : 4, r, g);
        @(posedge clk); #1;
        busy_cnt = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = obs(sel);
            chk($sformatf("%s c%0d", name, i + 1), 32'(o), 32'(exp_q[i]));
            if (o[1]) busy_cnt++;
            if (i != exp_q.size() - 1) begin
                scramble(sel, hold);
                @(posedge clk); #1;
            end
        end
        chk($sformatf("%s busy_cycles", name), 32'(busy_cnt), 32'(exp_busy));
    endtask

    initial begin
        vec_t tbl[7];
        int   cyc;
        logic [7:0] rp;
        int   rr, rg;

        tbl[0] = '{8'h09, 0,   0,  5,    "t1_1001"};
        tbl[1] = '{8'h09, 1,   0,  9,    "t2_rep_nogap"};
        tbl[2] = '{8'h0D, 2,   3,  19,   "t3_gap"};
        tbl[3] = '{8'h0F, 0,   5,  5,    "gap_unused"};
        tbl[4] = '{8'h00, 3,   1,  20,   "zeros"};
        tbl[5] = '{8'h06, 255, 0,  1025, "rep_max"};
        tbl[6] = '{8'h0A, 2,   15, 43,   "gap_max"};

        if4.start = 1'b0; if4.pattern = '0; if4.repeat_cnt = '0; if4.gap = '0;
        if8.start = 1'b0; if8.pattern = '0; if8.repeat_cnt = '0; if8.gap = '0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dut4", 32'(obs(0)), 32'h0);
        chk("reset dut8", 32'(obs(1)), 32'h0);

        // First vector also proves start on the first edge after release works.
        for (int v = 0; v < 7; v++)
            run_xfer(0, tbl[v].pat, tbl[v].r, tbl[v].g, 1'b0, v == 0, tbl[v].busy, tbl[v].name);

        // Start held high with pattern churning: one send of the original, then a
        // fresh accept only after busy has dropped.
        run_xfer(0, 8'h0B, 0, 0, 1'b1, 1'b0, 5, "hold");
        if4.pattern = 4'b0110; if4.repeat_cnt = '0; if4.gap = '0;
        @(posedge clk); #1;
        chk("hold new accept", 32'(obs(0)), 32'b0110);
        if4.start = 1'b0;
        cyc = 0;
        while (if4.busy && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold drain", 32'(if4.busy), 32'h0);

        // Async reset in cycle 3 of a 1001 send.
        @(negedge clk);
        if4.pattern = 4'b1001; if4.repeat_cnt = '0; if4.gap = '0; if4.start = 1'b1;
        @(posedge clk); #1;
        if4.start = 1'b0;
        chk("rst c1", 32'(obs(0)), 32'b1110);
        @(posedge clk); @(posedge clk); #1;
        chk("rst c3", 32'(obs(0)), 32'b0110);
        #1 rst_n = 1'b0;
        #1;
        chk("rst async", 32'(obs(0)), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst hold c%0d", i), 32'(obs(0)), 32'h0);
        end
        run_xfer(0, 8'h09, 0, 0, 1'b0, 1'b1, 5, "after_rst");

        // Wide instance: four sends of A5 with one idle bit between.
        run_xfer(1, 8'hA5, 3, 1, 1'b0, 1'b0, 36, "t6_w8");

        // Random transfers against the model and the busy-cycle formula.
        for (int t = 0; t < 25; t++) begin
            rp = 8'($urandom);
            rr = int'($urandom_range(0, 5));
            rg = int'($urandom_range(0, 4));
            if (t % 5 == 4)
                run_xfer(1, rp, rr % 4, rg, 1'b0, 1'b0, 8 * (rr % 4 + 1) + rg * (rr % 4) + 1,
                         $sformatf("rnd8_%0d", t));
            else
                run_xfer(0, {4'h0, rp[3:0]}, rr, rg, 1'b0, 1'b0, 4 * (rr + 1) + rg * rr + 1,
                         $sformatf("rnd4_%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
